// File: rtl/prog_ctr.sv
// Program-flow and flag stage behind the combinational ALU.
// Holds the architectural carry/zero flags, which feed the ALU SC_IN.
// Owns the program counter: sequential fetch, absolute jump and relative
// branch-on-zero.
// Runs the IDLE/RUN/DONE handshake, driven by Start and Halt.
module prog_ctr #(
    parameter int unsigned PW = 10,
    parameter int unsigned CW = 16
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Halt,
    input  logic          Jump,
    input  logic          Branch,
    input  logic [PW-1:0] Target,
    input  logic [7:0]    Offset,
    input  logic          FlagEn,
    input  logic          ALU_SC_OUT,
    input  logic          ALU_ZERO,
    output logic [PW-1:0] PC,
    output logic          CarryFlag,
    output logic          ZeroFlag,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [PW-1:0] r_pc;
    logic          r_carry;
    logic          r_zero;
    logic [CW-1:0] r_cnt;
    logic          r_running;
    logic          r_done;

    logic [1:0]    w_state_nxt;
    logic [PW-1:0] w_pc_nxt;
    logic          w_carry_nxt;
    logic          w_zero_nxt;
    logic [CW-1:0] w_cnt_nxt;

    logic [31:0]   w_off_sx;
    logic [PW-1:0] w_off;
    logic [PW-1:0] w_pc_inc;
    logic [PW-1:0] w_pc_rel;
    logic          w_br_taken;
    logic [CW-1:0] w_cnt_inc;

    // Offset sign-extended, then truncated to PC width so the add wraps mod 2^PW.
    assign w_off_sx = 32'(signed'(Offset));
    assign w_off    = w_off_sx[PW-1:0];
    assign w_pc_inc = r_pc + PW'(1);
    assign w_pc_rel = r_pc + w_off;

    // Branch tests the registered flag, never the ALU result of the same cycle.
    assign w_br_taken = Branch & r_zero;

    // Run counter saturates at all-ones instead of wrapping.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CW'(1);

    // Next-state, PC, flag and counter selection.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_carry_nxt = r_carry;
        w_zero_nxt  = r_zero;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            ST_IDLE: begin
                w_pc_nxt = '0;
                if (Start) begin
                    w_state_nxt = ST_RUN;
                    w_carry_nxt = 1'b0;
                    w_zero_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end

            ST_RUN: begin
                // The halting cycle is still a RUN cycle and is counted.
                w_cnt_nxt = w_cnt_inc;
                if (Halt) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    if (FlagEn) begin
                        w_carry_nxt = ALU_SC_OUT;
                        w_zero_nxt  = ALU_ZERO;
                    end
                    if (Jump) begin
                        w_pc_nxt = Target;
                    end else if (w_br_taken) begin
                        w_pc_nxt = w_pc_rel;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end

            ST_DONE: begin
                if (Start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = '0;
                    w_carry_nxt = 1'b0;
                    w_zero_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean idle.
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = '0;
                w_carry_nxt = 1'b0;
                w_zero_nxt  = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Architectural state and registered status outputs.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_cnt     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_carry   <= w_carry_nxt;
            r_zero    <= w_zero_nxt;
            r_cnt     <= w_cnt_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_DONE);
        end
    end

    assign PC         = r_pc;
    assign CarryFlag  = r_carry;
    assign ZeroFlag   = r_zero;
    assign Running    = r_running;
    assign Done       = r_done;
    assign CycleCount = r_cnt;

endmodule

// File: tb/tb_prog_ctr.sv
// Scoreboard bench for prog_ctr: directed vectors push hand-computed expectations,
// a monitor pops one per clock edge (or per async-reset event) and compares.
// A second instance with a 3-bit counter exercises counter saturation.
module tb_prog_ctr;

    localparam int PW = 10;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          Start, Halt, Jump, Branch, FlagEn, ALU_SC_OUT, ALU_ZERO;
    logic [PW-1:0] Target;
    logic [7:0]    Offset;

    logic [PW-1:0] PC;
    logic          CarryFlag, ZeroFlag, Running, Done;
    logic [CW-1:0] CycleCount;

    logic [PW-1:0] s_pc;
    logic          s_carry, s_zero, s_running, s_done;
    logic [2:0]    s_cnt;

    prog_ctr #(.PW(PW), .CW(CW)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Halt(Halt), .Jump(Jump),
        .Branch(Branch), .Target(Target), .Offset(Offset), .FlagEn(FlagEn),
        .ALU_SC_OUT(ALU_SC_OUT), .ALU_ZERO(ALU_ZERO), .PC(PC),
        .CarryFlag(CarryFlag), .ZeroFlag(ZeroFlag), .Running(Running),
        .Done(Done), .CycleCount(CycleCount)
    );

    prog_ctr #(.PW(PW), .CW(3)) dut_sat (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Halt(Halt), .Jump(Jump),
        .Branch(Branch), .Target(Target), .Offset(Offset), .FlagEn(FlagEn),
        .ALU_SC_OUT(ALU_SC_OUT), .ALU_ZERO(ALU_ZERO), .PC(s_pc),
        .CarryFlag(s_carry), .ZeroFlag(s_zero), .Running(s_running),
        .Done(s_done), .CycleCount(s_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       nm;
        logic [9:0]  pc;
        logic        c;
        logic        z;
        logic        run;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t m;
    logic [2:0] sat_exp;
    int   checks = 0;
    int   errors = 0;
    event async_ev;

    task automatic drive(input logic st, input logic hl, input logic jp, input logic br,
                         input logic [9:0] tg, input logic [7:0] of, input logic fe,
                         input logic sc, input logic zr);
        @(negedge CLK);
        Start = st; Halt = hl; Jump = jp; Branch = br; Target = tg; Offset = of;
        FlagEn = fe; ALU_SC_OUT = sc; ALU_ZERO = zr;
    endtask

    task automatic expect_out(input string nm, input logic [9:0] pc, input logic c,
                              input logic z, input logic run, input logic done,
                              input logic [15:0] cnt);
        exp_t e;
        e.nm = nm; e.pc = pc; e.c = c; e.z = z; e.run = run; e.done = done; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic plain();
        drive(0, 0, 0, 0, 10'h000, 8'h00, 0, 0, 0);
    endtask

    // Monitor: one expectation per edge / async event.
    initial begin
        forever begin
            @(posedge CLK or async_ev);
            #1;
            if (q.size() > 0) begin
                m = q.pop_front();
                sat_exp = (m.cnt > 16'd7) ? 3'd7 : m.cnt[2:0];
                checks++;
                if (PC !== m.pc || CarryFlag !== m.c || ZeroFlag !== m.z ||
                    Running !== m.run || Done !== m.done || CycleCount !== m.cnt ||
                    s_cnt !== sat_exp) begin
                    errors++;
                    $display("FAIL %s: got pc=%h c=%b z=%b run=%b done=%b cnt=%0d sat=%0d, want pc=%h c=%b z=%b run=%b done=%b cnt=%0d sat=%0d",
                             m.nm, PC, CarryFlag, ZeroFlag, Running, Done, CycleCount,
                             s_cnt, m.pc, m.c, m.z, m.run, m.done, m.cnt, sat_exp);
                end
            end
        end
    end

    initial begin
        Reset = 1'b1;
        Start = 0; Halt = 0; Jump = 0; Branch = 0; Target = '0; Offset = '0;
        FlagEn = 0; ALU_SC_OUT = 0; ALU_ZERO = 0;

        plain();                                    expect_out("reset", 10'h000, 0, 0, 0, 0, 0);
        @(negedge CLK); Reset = 1'b0;
        drive(0, 0, 0, 0, 10'h000, 8'h00, 1, 1, 1); expect_out("idle_fe", 10'h000, 0, 0, 0, 0, 0);

        // Start and sequential fetch; Start is ignored in RUN.
        drive(1, 0, 0, 0, 10'h000, 8'h00, 0, 0, 0); expect_out("start", 10'h000, 0, 0, 1, 0, 0);
        plain();                                    expect_out("pc1", 10'h001, 0, 0, 1, 0, 1);
        drive(1, 0, 0, 0, 10'h000, 8'h00, 0, 0, 0); expect_out("pc2_st", 10'h002, 0, 0, 1, 0, 2);
        plain();                                    expect_out("pc3", 10'h003, 0, 0, 1, 0, 3);

        // Set flags, then taken branch -4.
        drive(0, 0, 0, 0, 10'h000, 8'h00, 1, 1, 1); expect_out("flags", 10'h004, 1, 1, 1, 0, 4);
        drive(0, 0, 0, 1, 10'h000, 8'hFC, 0, 0, 0); expect_out("br_tk", 10'h000, 1, 1, 1, 0, 5);
        drive(0, 0, 1, 0, 10'h004, 8'h00, 0, 0, 0); expect_out("jmp4", 10'h004, 1, 1, 1, 0, 6);
        drive(0, 0, 0, 0, 10'h000, 8'h00, 1, 0, 0); expect_out("flags0", 10'h005, 0, 0, 1, 0, 7);
        drive(0, 0, 0, 1, 10'h000, 8'hFC, 0, 0, 0); expect_out("br_nt", 10'h006, 0, 0, 1, 0, 8);

        // Same-cycle compare and branch uses the old ZeroFlag.
        drive(0, 0, 0, 1, 10'h000, 8'hFC, 1, 1, 1); expect_out("hazard", 10'h007, 1, 1, 1, 0, 9);

        // Jump beats branch, PC wraps, relative wrap both ways, self-loop.
        drive(0, 0, 1, 1, 10'h3FF, 8'hFC, 0, 0, 0); expect_out("jmp_pri", 10'h3FF, 1, 1, 1, 0, 10);
        plain();                                    expect_out("wrap", 10'h000, 1, 1, 1, 0, 11);
        drive(0, 0, 0, 1, 10'h000, 8'hFC, 0, 0, 0); expect_out("br_under", 10'h3FC, 1, 1, 1, 0, 12);
        drive(0, 0, 0, 1, 10'h000, 8'h08, 0, 0, 0); expect_out("br_over", 10'h004, 1, 1, 1, 0, 13);
        drive(0, 0, 0, 1, 10'h000, 8'h00, 0, 0, 0); expect_out("selfloop", 10'h004, 1, 1, 1, 0, 14);

        // Halt beats Jump and FlagEn; DONE holds.
        drive(0, 1, 1, 0, 10'h055, 8'h00, 1, 0, 0); expect_out("halt_jmp", 10'h004, 1, 1, 0, 1, 15);
        drive(0, 0, 1, 0, 10'h055, 8'h00, 1, 0, 0); expect_out("done_hold", 10'h004, 1, 1, 0, 1, 15);
        drive(1, 0, 0, 0, 10'h000, 8'h00, 0, 0, 0); expect_out("restart", 10'h000, 0, 0, 1, 0, 0);

        // Halt at 0x25 with flags set, then hold for five cycles.
        drive(0, 0, 1, 0, 10'h024, 8'h00, 1, 1, 1); expect_out("jmp24", 10'h024, 1, 1, 1, 0, 1);
        plain();                                    expect_out("pc25", 10'h025, 1, 1, 1, 0, 2);
        drive(0, 1, 0, 0, 10'h000, 8'h00, 0, 0, 0); expect_out("halt25", 10'h025, 1, 1, 0, 1, 3);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 10'h000, 8'h00, ~i[0], 0, 0);
            expect_out("done25", 10'h025, 1, 1, 0, 1, 3);
        end
        drive(1, 0, 0, 0, 10'h000, 8'h00, 1, 1, 1); expect_out("restart2", 10'h000, 0, 0, 1, 0, 0);

        // Asynchronous reset mid-run, away from any clock edge.
        drive(0, 0, 1, 0, 10'h080, 8'h00, 1, 1, 1); expect_out("jmp80", 10'h080, 1, 1, 1, 0, 1);
        @(negedge CLK);
        #2;
        Reset = 1'b1;
        expect_out("async_rst", 10'h000, 0, 0, 0, 0, 0);
        ->async_ev;
        plain();                                    expect_out("rst_hold", 10'h000, 0, 0, 0, 0, 0);
        @(negedge CLK); Reset = 1'b0;
        plain();                                    expect_out("need_start", 10'h000, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 10'h000, 8'h00, 0, 0, 0); expect_out("resume", 10'h000, 0, 0, 1, 0, 0);

        // Run on; the 3-bit counter instance saturates at 7.
        for (int i = 1; i <= 10; i++) begin
            plain();
            expect_out("run_sat", 10'(i), 0, 0, 1, 0, 16'(i));
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge CLK);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_ctr.md
Name: prog_ctr

Overview:
- Program-flow and flag stage that sits directly downstream of the combinational ALU.
- Registers the ALU carry/shift-out and zero outputs into architectural flags, and feeds the carry flag back as the ALU's SC_IN for the next instruction.
- Owns the program counter: sequential fetch, absolute jumps, relative branch-on-zero (the compare result), and the Start/Halt/Done run handshake with the testbench.

Parameters:
- PW, 10, program counter width in bits (instruction memory depth 2^PW).
- CW, 16, width of the run-cycle counter.

Ports:
- CLK  input  1  clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  level; requests a (re)start of the program from address 0.
- Halt  input  1  decoded halt instruction at current PC.
- Jump  input  1  decoded unconditional absolute jump.
- Branch  input  1  decoded conditional branch (taken when ZeroFlag=1).
- Target  input  PW  absolute jump address.
- Offset  input  8  signed two's-complement branch displacement.
- FlagEn  input  1  current instruction writes flags.
- ALU_SC_OUT  input  1  ALU shift/carry out.
- ALU_ZERO  input  1  ALU zero flag (1 = compare equal / result zero).
- PC  output  PW  address of the instruction being executed.
- CarryFlag  output  1  registered carry; drives ALU SC_IN.
- ZeroFlag  output  1  registered zero flag.
- Running  output  1  high while in RUN.
- Done  output  1  high while in DONE.
- CycleCount  output  CW  RUN cycles since last start.

Behaviour:
- One clock, CLK. Reset is asynchronous and active-high: PC=0, CarryFlag=0, ZeroFlag=0, CycleCount=0, state=IDLE, Running=0, Done=0. Reset asserted mid-program aborts immediately; no partial update survives.
- All outputs are registered. Running = (state==RUN). Done = (state==DONE).
- State IDLE:
  - PC held at 0.
  - Start=1: next state RUN. PC stays 0 so the first executed instruction is address 0. CycleCount and flags are cleared.
- State RUN, evaluated each rising edge. Priority: Halt > Jump > taken Branch > increment.
  - Halt=1: next state DONE. PC and flags hold. CycleCount still counts this cycle.
  - Jump=1: PC <= Target.
  - Branch=1 and ZeroFlag=1: PC <= PC + sign_extend(Offset) mod 2^PW. Offset=0 is a self-loop. Wrap below 0 or above 2^PW-1 is silent.
  - Branch=1 and ZeroFlag=0: PC <= PC+1.
  - Otherwise: PC <= PC+1. PC = 2^PW-1 wraps to 0.
  - Start is ignored while in RUN.
- Flag rules:
  - Flags update only in RUN with FlagEn=1 and Halt=0: CarryFlag <= ALU_SC_OUT, ZeroFlag <= ALU_ZERO.
  - A Branch in the same cycle as FlagEn tests the OLD ZeroFlag (pre-edge value). Compare-then-branch therefore takes two instructions.
  - FlagEn is ignored in IDLE and DONE.
- CycleCount: increments by 1 on every RUN cycle and saturates at 2^CW-1 (no wrap).
- State DONE:
  - PC, flags and CycleCount hold.
  - Start=1: next state RUN with PC <= 0, flags <= 0, CycleCount <= 0. Done drops on the same edge.
- Simultaneous Jump and Branch: Jump wins. Simultaneous Halt with anything: Halt wins.

Test Plan:
- Reset then Start pulse: Running rises on 1st edge with PC=0, then PC=1,2,3 on the next edges; Done=0; CycleCount=3 after 3 RUN cycles.
- Flags and branch: at PC=4, FlagEn=1, ALU_ZERO=1, ALU_SC_OUT=1 -> ZeroFlag=1, CarryFlag=1. Next cycle Branch=1, Offset=8'hFC -> PC=0. Repeat with ALU_ZERO=0 -> PC=6 (not taken).
- Same-cycle hazard: ZeroFlag=0, Branch=1 and FlagEn=1 with ALU_ZERO=1 together -> branch not taken (PC+1), ZeroFlag becomes 1 after the edge.
- Priority and wrap: Jump=1, Branch=1, Target=10'h3FF, ZeroFlag=1 -> PC=3FF; next plain cycle -> PC=0. Halt+Jump together -> DONE, PC unchanged.
- Halt/restart: Halt at PC=0x25 -> Done=1, PC holds 0x25 over 5 cycles, FlagEn toggling has no effect. Start=1 -> PC=0, flags 0, CycleCount=0, Running=1.
- Async reset mid-RUN at PC=0x80 with flags set: outputs clear without waiting for a clock edge; state is IDLE; Start is required to resume.
